// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single-port memory
// with fixed read latency. Define MEM_ARB_ROUND_ROBIN_EN for round-robin on contention.
//
// state | meaning
// IDLE  | waiting for a request; sampling edge latches winner and access fields
// ISSUE | mem_en high for this single cycle; latency counter loaded
// WAIT  | counter runs down; read data captured on the last wait cycle
// ACK   | winner's ack high for one cycle; requests ignored
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt;
    logic       grant_d;
    logic       we_l;
    logic       pick_d;
    logic       any_req;
    logic       done;

    assign any_req = i_req | d_req;
    assign done    = (state == WAIT) && (cnt <= 4'd1);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_d;

    always_comb begin
        pick_d = d_req;
        if (i_req && d_req)
            pick_d = ~last_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_d <= 1'b1;
        else if (state == IDLE && any_req)
            last_d <= pick_d;
    end
`else
    assign pick_d = d_req;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (done) state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= 4'd0;
            grant_d   <= 1'b0;
            we_l      <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            i_ack  <= 1'b0;
            d_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_d  <= pick_d;
                        we_l     <= pick_d & d_we;
                        mem_en   <= 1'b1;
                        mem_we   <= pick_d & d_we;
                        mem_addr <= pick_d ? d_addr : i_addr;
                        if (pick_d)
                            mem_wdata <= d_wdata;
                    end
                end
                ISSUE: cnt <= 4'(LATENCY);
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (done) begin
                        // a write leaves d_rdata holding the last read word
                        if (!grant_d)
                            i_rdata <= mem_rdata;
                        else if (!we_l)
                            d_rdata <= mem_rdata;
                        i_ack <= ~grant_d;
                        d_ack <= grant_d;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: one LATENCY=1 and one LATENCY=15 instance, selected in turn,
// checked against a transaction-level model of grant, timing and read data.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0;

    logic        i_ack_a, d_ack_a, mem_en_a, mem_we_a;
    logic [15:0] i_rdata_a, d_rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
    logic        i_ack_b, d_ack_b, mem_en_b, mem_we_b;
    logic [15:0] i_rdata_b, d_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;
    logic [15:0] pipe_b [15];

    int errors = 0;
    int checks = 0;

    bit          last_d [2] = '{1'b1, 1'b1};
    logic [15:0] exp_ir [2] = '{16'h0, 16'h0};
    logic [15:0] exp_dr [2] = '{16'h0, 16'h0};
    int          lat    [2] = '{1, 15};

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .LATENCY(1)) dut_a (
        .clk(clk), .rst(rst),
        .i_req(i_req & ~sel), .i_addr(i_addr), .i_rdata(i_rdata_a), .i_ack(i_ack_a),
        .d_req(d_req & ~sel), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata_a), .d_ack(d_ack_a),
        .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
        .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a)
    );

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .LATENCY(15)) dut_b (
        .clk(clk), .rst(rst),
        .i_req(i_req & sel), .i_addr(i_addr), .i_rdata(i_rdata_b), .i_ack(i_ack_b),
        .d_req(d_req & sel), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata_b), .d_ack(d_ack_b),
        .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
    );

    wire        ack_i   = sel ? i_ack_b     : i_ack_a;
    wire        ack_d   = sel ? d_ack_b     : d_ack_a;
    wire [15:0] rd_i    = sel ? i_rdata_b   : i_rdata_a;
    wire [15:0] rd_d    = sel ? d_rdata_b   : d_rdata_a;
    wire        m_en    = sel ? mem_en_b    : mem_en_a;
    wire        m_we    = sel ? mem_we_b    : mem_we_a;
    wire [15:0] m_addr  = sel ? mem_addr_b  : mem_addr_a;
    wire [15:0] m_wdata = sel ? mem_wdata_b : mem_wdata_a;

    function automatic logic [15:0] mem_fn(logic [15:0] a);
        if (a == 16'h0010)
            return 16'hBEEF;
        return 16'(a * 16'h9E37 + 16'h1234);
    endfunction

    // memory: read word valid exactly LATENCY cycles after mem_en, junk otherwise
    always @(posedge clk)
        mem_rdata_a <= (mem_en_a && !mem_we_a) ? mem_fn(mem_addr_a) : 16'($urandom);

    always @(posedge clk) begin
        pipe_b[0] <= (mem_en_b && !mem_we_b) ? mem_fn(mem_addr_b) : 16'($urandom);
        for (int k = 1; k < 15; k++)
            pipe_b[k] <= (pipe_b[k-1] === 16'hxxxx) ? 16'($urandom) : pipe_b[k-1];
    end
    assign mem_rdata_b = pipe_b[14];

    function automatic bit pick_d(bit ir, bit dr);
        if (ir && dr) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            return ~last_d[sel];
`else
            return 1'b1;
`endif
        end
        return dr;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            last_d[k] = 1'b1;
            exp_ir[k] = 16'h0;
            exp_dr[k] = 16'h0;
        end
    endtask

    // call at a negedge with the DUT in IDLE and requests already driven
    task automatic do_access(input bit drop, output bit got_d);
        bit          wd, ewe;
        logic [15:0] ea, ewd, erd, ca, cw;
        logic        cwe;
        int          n, en_cnt, en_at;
        wd  = pick_d(i_req, d_req);
        ea  = wd ? d_addr : i_addr;
        ewe = wd & d_we;
        ewd = d_wdata;
        erd = mem_fn(ea);
        n = 0; en_cnt = 0; en_at = 0; ca = '0; cw = '0; cwe = 1'b0;
        @(posedge clk);
        do begin
            @(negedge clk);
            n++;
            if (m_en) begin
                en_cnt++;
                en_at = n;
                ca    = m_addr;
                cwe   = m_we;
                cw    = m_wdata;
            end
            if (n == 1 && drop) begin
                i_req   = 1'b0;
                d_req   = 1'b0;
                i_addr  = 16'($urandom);
                d_addr  = 16'($urandom);
                d_we    = 1'($urandom);
                d_wdata = 16'($urandom);
            end
        end while (!(ack_i || ack_d) && n < 40);
        got_d = ack_d;
        chk("ack_cycle", n, lat[sel] + 2);
        chk("ack_port", {30'd0, ack_i, ack_d}, wd ? 32'd1 : 32'd2);
        chk("mem_en_count", en_cnt, 1);
        chk("mem_en_cycle", en_at, 1);
        chk("mem_addr", {16'd0, ca}, {16'd0, ea});
        chk("mem_we", {31'd0, cwe}, {31'd0, ewe});
        if (ewe)
            chk("mem_wdata", {16'd0, cw}, {16'd0, ewd});
        if (!wd)
            exp_ir[sel] = erd;
        else if (!ewe)
            exp_dr[sel] = erd;
        last_d[sel] = wd;
        chk("i_rdata", {16'd0, rd_i}, {16'd0, exp_ir[sel]});
        chk("d_rdata", {16'd0, rd_d}, {16'd0, exp_dr[sel]});
        @(negedge clk);
        chk("ack_pulse", {30'd0, ack_i, ack_d}, 32'd0);
        chk("i_rdata_hold", {16'd0, rd_i}, {16'd0, exp_ir[sel]});
        chk("d_rdata_hold", {16'd0, rd_d}, {16'd0, exp_dr[sel]});
    endtask

    task automatic random_accesses(input int count);
        bit       gd;
        bit [1:0] r;
        for (int k = 0; k < count; k++) begin
            r       = 2'($urandom_range(1, 3));
            i_req   = r[0];
            d_req   = r[1];
            i_addr  = 16'($urandom);
            d_addr  = 16'($urandom);
            d_we    = 1'($urandom);
            d_wdata = 16'($urandom);
            do_access($urandom_range(0, 3) == 0, gd);
        end
        i_req = 1'b0;
        d_req = 1'b0;
    endtask

    initial begin
        bit    gd;
        string order, exp_order;
        int    seen_ack, seen_en;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_ctrl", {28'd0, ack_i, ack_d, m_en, m_we}, 32'd0);
        chk("rst_addr_wdata", {m_addr, m_wdata}, 32'd0);
        chk("rst_rdata", {rd_i, rd_d}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // fetch read returning 0xBEEF
        i_req = 1'b1; i_addr = 16'h0010;
        do_access(1'b0, gd);
        chk("fetch_beef", {16'd0, rd_i}, 32'h0000BEEF);
        i_req = 1'b0;

        // data write
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h8000; d_wdata = 16'h1234;
        do_access(1'b0, gd);
        chk("write_keeps_d_rdata", {16'd0, rd_d}, 32'd0);
        d_req = 1'b0; d_we = 1'b0;

        // both ports held for four accesses
        order = "";
        i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            i_addr = 16'($urandom);
            d_addr = 16'($urandom);
            do_access(1'b0, gd);
            order = {order, gd ? "D" : "I"};
        end
        i_req = 1'b0; d_req = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_order = "IDID";
`else
        exp_order = "DDDD";
`endif
        checks++;
        assert (order == exp_order) else begin
            errors++;
            $error("FAIL grant_order: observed %s expected %s", order, exp_order);
        end

        random_accesses(16);

        // long-latency instance
        sel = 1'b1;
        @(negedge clk);
        i_req = 1'b1; i_addr = 16'h0042;
        do_access(1'b0, gd);
        i_req = 1'b0;
        random_accesses(6);

        // reset in the middle of WAIT
        i_req = 1'b1; i_addr = 16'h0777;
        @(posedge clk);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        i_req = 1'b0;
        #1;
        model_reset();
        chk("midrst_ctrl", {28'd0, ack_i, ack_d, m_en, m_we}, 32'd0);
        chk("midrst_addr_wdata", {m_addr, m_wdata}, 32'd0);
        chk("midrst_rdata", {rd_i, rd_d}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen_ack = 0; seen_en = 0;
        repeat (25) begin
            @(negedge clk);
            if (ack_i || ack_d) seen_ack++;
            if (m_en) seen_en++;
        end
        chk("no_ack_after_rst", seen_ack, 0);
        chk("no_en_after_rst", seen_en, 0);
        i_req = 1'b1; i_addr = 16'h0010;
        do_access(1'b0, gd);
        i_req = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
